bus_arbiter: RTL

- Round-robin arbiter that sits directly downstream of N per-core bus master ports (one per RISC_V_ hart wrapper, multi-core build).
- Multiplexes their single-outstanding bus transactions onto one shared slave bus (memory or interconnect).
- Routes the slave's ack and read data back to the granted core.
- One transaction in flight at a time; fair rotation between masters.

---
 rtl/arvi_bus_pkg.sv | 50 +++++
 rtl/bus_arbiter_rr_priority_enc.sv | 27 ++
 rtl/bus_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/arvi_bus_pkg.sv
// Shared bus definitions for the core-side bus fabric.
// Contents:
//   arb_state_e : arbiter FSM states (IDLE, GRANT, RELEASE)
//   BYTE_EN_W   : byte-enable width of the bus
//   rr_pick()   : round-robin search returning the winning index and a found flag
// XLEN defaults to 32 when the build does not define it.
`ifndef XLEN
`define XLEN 32
`endif

package arvi_bus_pkg;

    localparam int unsigned BYTE_EN_W    = 4;
    localparam int unsigned RR_MAX_N     = 8;
    localparam int unsigned RR_MAX_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                    found;
        logic [RR_MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Scan last+1, last+2, ... modulo n; the first requester found wins.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_N-1:0]     req,
        input logic [RR_MAX_IDX_W-1:0] last,
        input int unsigned             n
    );
        rr_pick_t    res;
        int unsigned k;
        res.found = 1'b0;
        res.idx   = '0;
        for (int unsigned i = 1; i <= RR_MAX_N; i++) begin
            if ((i <= n) && !res.found) begin
                k = (32'(last) + i) % n;
                if (req[k[RR_MAX_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = k[RR_MAX_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_priority_enc.sv
// rr_priority_enc: combinational round-robin picker.
// Ports:
//   req_i       : request vector, one bit per requester
//   last_i      : index served last (it becomes lowest priority)
//   grant_idx_o : winning index (0 when no request)
//   valid_o     : at least one request present
module rr_priority_enc
    import arvi_bus_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             valid_o
);

    rr_pick_t pick;

    always_comb begin
        pick        = rr_pick(RR_MAX_N'(req_i), RR_MAX_IDX_W'(last_i), N);
        grant_idx_o = IDX_W'(pick.idx);
        valid_o     = pick.found;
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter multiplexing N single-outstanding core bus
// masters onto one shared slave bus; one transaction in flight at a time.
// Optional feature macro: BUS_ARB_ATOMIC_LOCK_EN (adds i_m_atomic and a lock
// that keeps the bus on one master across an atomic sequence).
// Ports:
//   i_clk, i_rst                  : clock, synchronous active-high reset
//   i_m_bus_en/wr_en/addr/wr_data/byte_en : flattened master requests
//   o_m_ack, o_m_rd_data          : one-hot ack and broadcast read data to masters
//   o_bus_en/wr_en/addr/wr_data/byte_en   : slave request (valid only in GRANT)
//   i_ack, i_rd_data              : slave completion and read data
//   o_grant_idx                   : current or last grant (debug)
//   o_busy                        : high while in GRANT
module bus_arbiter
    import arvi_bus_pkg::*;
#(
    parameter  int unsigned N_MASTERS = 2,
    parameter  int unsigned XLEN      = `XLEN,
    localparam int unsigned IDX_W     = $clog2(N_MASTERS)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [N_MASTERS-1:0]           i_m_bus_en,
    input  logic [N_MASTERS-1:0]           i_m_wr_en,
    input  logic [N_MASTERS*XLEN-1:0]      i_m_addr,
    input  logic [N_MASTERS*XLEN-1:0]      i_m_wr_data,
    input  logic [N_MASTERS*BYTE_EN_W-1:0] i_m_byte_en,
`ifdef BUS_ARB_ATOMIC_LOCK_EN
    input  logic [N_MASTERS-1:0]           i_m_atomic,
`endif
    output logic [N_MASTERS-1:0]           o_m_ack,
    output logic [XLEN-1:0]                o_m_rd_data,
    output logic                           o_bus_en,
    output logic                           o_wr_en,
    output logic [XLEN-1:0]                o_addr,
    output logic [XLEN-1:0]                o_wr_data,
    output logic [BYTE_EN_W-1:0]           o_byte_en,
    input  logic                           i_ack,
    input  logic [XLEN-1:0]                i_rd_data,
    output logic [IDX_W-1:0]               o_grant_idx,
    output logic                           o_busy
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

`ifdef BUS_ARB_ATOMIC_LOCK_EN
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
`endif

    // Round-robin candidate from the current requests
    rr_priority_enc #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_priority_enc (
        .req_i       (i_m_bus_en),
        .last_i      (last_q),
        .grant_idx_o (pick_idx),
        .valid_o     (pick_valid)
    );

    // State registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= IDX_W'(N_MASTERS - 1);
`ifdef BUS_ARB_ATOMIC_LOCK_EN
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
`ifdef BUS_ARB_ATOMIC_LOCK_EN
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
`endif
        end
    end

    // Next-state and bus muxing
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
`ifdef BUS_ARB_ATOMIC_LOCK_EN
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
`endif
        o_m_ack     = '0;
        o_m_rd_data = '0;
        o_bus_en    = 1'b0;
        o_wr_en     = 1'b0;
        o_addr      = '0;
        o_wr_data   = '0;
        o_byte_en   = '0;
        o_busy      = 1'b0;

        unique case (state_q)
            IDLE: begin
`ifdef BUS_ARB_ATOMIC_LOCK_EN
                // A locked master owns the bus; everyone else waits.
                if (lock_q) begin
                    if (i_m_bus_en[lock_idx_q]) begin
                        grant_d = lock_idx_q;
                        state_d = GRANT;
                    end
                end else if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = GRANT;
                end
`else
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = GRANT;
                end
`endif
            end

            GRANT: begin
                o_busy    = 1'b1;
                o_bus_en  = i_m_bus_en[grant_q];
                o_wr_en   = i_m_wr_en[grant_q];
                o_addr    = i_m_addr[32'(grant_q)*XLEN +: XLEN];
                o_wr_data = i_m_wr_data[32'(grant_q)*XLEN +: XLEN];
                o_byte_en = i_m_byte_en[32'(grant_q)*BYTE_EN_W +: BYTE_EN_W];
                if (!i_m_bus_en[grant_q]) begin
                    // Master withdrew: abort without ack, rotation untouched.
                    state_d = IDLE;
                end else if (i_ack) begin
                    o_m_ack[grant_q] = 1'b1;
                    o_m_rd_data      = i_rd_data;
                    state_d          = RELEASE;
`ifdef BUS_ARB_ATOMIC_LOCK_EN
                    if (!lock_q) begin
                        last_d = grant_q;
                    end
                    if (i_m_atomic[grant_q]) begin
                        lock_d     = 1'b1;
                        lock_idx_d = grant_q;
                    end else begin
                        lock_d     = 1'b0;
                    end
`else
                    last_d = grant_q;
`endif
                end
            end

            RELEASE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_grant_idx = grant_q;

endmodule
